clk_rate_gen: RTL and testbench
===============================

Name: clk_rate_gen

Overview:
- Programmable rate generator (NCO) in the clk_ref domain; produces a tick strobe and a square-wave clk_out at a configured fraction of CLK_REF_RATE_HZ.
- Counterpart of the clock-rate monitor: it produces known-rate test signals, where the monitor measures them. Used for self-test of rate measurement paths and as a general timebase strobe.
- Tick rate: f_tick = cfg_incr * CLK_REF_RATE_HZ / 2^ACC_WIDTH.
- Supports continuous mode and finite-burst mode.

Parameters:
- CLK_REF_RATE_HZ, 100000000, reference clock frequency; documentation and bench scaling only.
- ACC_WIDTH, 32, phase accumulator and increment width.
- COUNTER_WIDTH, 32, width of the burst length and the tick counter.

Ports:
- clk_ref  input  1  reference clock; all logic on its rising edge.
- reset_in_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  configuration offer.
- cfg_ready  output  1  configuration can be accepted.
- cfg_incr  input  ACC_WIDTH  phase increment per clk_ref cycle.
- cfg_burst  input  COUNTER_WIDTH  number of ticks to emit; 0 = continuous.
- start  input  1  begin generation (single-cycle pulse or level).
- stop  input  1  abort generation.
- busy  output  1  state == RUN.
- done  output  1  burst completed; held until the next start or cfg accept.
- tick  output  1  one-cycle strobe on each accumulator carry.
- clk_out  output  1  registered accumulator MSB (~50% duty square wave).
- tick_count  output  COUNTER_WIDTH  ticks emitted since the last start.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; acc=0; incr_r=0; burst_r=0.
  - tick=0, clk_out=0, busy=0, done=0, tick_count=0, cfg_ready=1.
- States: IDLE, RUN, DONE.
- cfg_ready=1 in IDLE and DONE, 0 in RUN.
- Config accept: when cfg_valid & cfg_ready, latch cfg_incr->incr_r and cfg_burst->burst_r at that edge, and clear done.
- Config is never changed mid-run.
- IDLE/DONE -> RUN on start & !stop:
  - acc<=0, tick_count<=0, done<=0.
  - If a cfg accept occurs in the same cycle, the run uses the newly accepted values.
- RUN, every cycle:
  - sum = {1'b0,acc} + {1'b0,incr_r} (ACC_WIDTH+1 bits); acc<=sum[ACC_WIDTH-1:0].
  - tick<=sum[ACC_WIDTH].
  - clk_out<=sum[ACC_WIDTH-1].
  - tick_count increments on each carry; it wraps modulo 2^COUNTER_WIDTH in continuous mode.
- Latency: the first add occurs in the first RUN cycle. tick is high in the k-th RUN cycle, where k = ceil(2^ACC_WIDTH / incr_r).
- Burst (burst_r != 0):
  - On the carry that takes tick_count to burst_r, the final tick is emitted and the state goes RUN->DONE.
  - done<=1, clk_out<=0, acc held.
- RUN -> IDLE on stop:
  - tick<=0, clk_out<=0, acc<=0; done stays 0; tick_count holds its value.
  - stop wins over start and over a burst-final carry in the same cycle. Any carry in that cycle is not emitted and not counted.
- stop in IDLE/DONE: no effect.
- start in RUN: ignored.
- incr_r=0: RUN with no ticks and clk_out=0 until stop.
- incr_r >= 2^(ACC_WIDTH-1): tick may be high on consecutive cycles. This is legal; every carry counts.
- incr_r = 2^ACC_WIDTH-1: tick high in every RUN cycle except the first.
- Outside RUN: tick=0 and clk_out=0.
- busy is a registered decode of state.
- Reset mid-run: immediate return to the reset values; no partial tick.

Test Plan:
- ACC_WIDTH=8, cfg_incr=64, burst=0, start -> tick in RUN cycles 4, 8, 12…; clk_out pattern 0,1,1,0 repeating (period 4, duty 2/4); tick_count=5 after 20 cycles.
- ACC_WIDTH=8, cfg_incr=3, burst=0 -> exactly 3 ticks per 256 RUN cycles (first at cycle 86); tick_count=30 after 2560 cycles.
- ACC_WIDTH=8, cfg_incr=128, burst=3 -> ticks at RUN cycles 2, 4, 6; state DONE and done=1 after cycle 6; tick_count=3; cfg_ready=1; tick stays 0 afterward.
- Handshakes:
  - cfg_valid in RUN is not accepted (cfg_ready=0).
  - cfg accept + start in the same cycle, with cfg_incr=64 replacing a prior 32 -> first tick at cycle 4, not 8.
- stop asserted at RUN cycle 10 with incr=64 -> IDLE next edge; tick_count holds 2; no tick at cycle 12; start+stop together in IDLE -> stays IDLE.
- Defaults (32-bit), cfg_incr=2^30 at 100 MHz, fed to the clock-rate monitor as its test clock -> monitor reports 25,000,000 per second ±1; reset_in_n pulsed low mid-run -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/clk_rate_gen.sv
// NCO rate generator: phase accumulator emits a tick on every carry, clk_out is the registered accumulator MSB.
// Latency: first add in the first RUN cycle; tick/clk_out are registered (one cycle after the add).
// Backpressure: cfg_ready is low while running; config offers are only taken in IDLE/DONE.
module clk_rate_gen #(
    parameter int CLK_REF_RATE_HZ = 100000000,
    parameter int ACC_WIDTH       = 32,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                     clk_ref,
    input  logic                     reset_in_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_WIDTH-1:0]     cfg_incr,
    input  logic [COUNTER_WIDTH-1:0] cfg_burst,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic                     tick,
    output logic                     clk_out,
    output logic [COUNTER_WIDTH-1:0] tick_count
);

    if (CLK_REF_RATE_HZ <= 0) begin : g_bad_rate
        $error("clk_rate_gen: CLK_REF_RATE_HZ must be positive");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     acc_nxt;
    logic [ACC_WIDTH-1:0]     incr_r;
    logic [ACC_WIDTH-1:0]     incr_nxt;
    logic [COUNTER_WIDTH-1:0] burst_r;
    logic [COUNTER_WIDTH-1:0] burst_nxt;
    logic [COUNTER_WIDTH-1:0] count_nxt;
    logic [COUNTER_WIDTH-1:0] count_inc;
    logic                     tick_nxt;
    logic                     clk_out_nxt;
    logic                     done_nxt;
    logic [ACC_WIDTH:0]       sum;
    logic                     cfg_accept;
    logic                     carry;
    logic                     last_tick;

    assign cfg_ready  = (state != RUN);
    assign cfg_accept = cfg_valid & cfg_ready;
    assign sum        = {1'b0, acc} + {1'b0, incr_r};
    assign carry      = sum[ACC_WIDTH];
    assign count_inc  = tick_count + COUNTER_WIDTH'(1);
    // burst_r == 0 means continuous, so the final-carry compare must never fire then
    assign last_tick  = carry && (burst_r != '0) && (count_inc == burst_r);

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        incr_nxt    = incr_r;
        burst_nxt   = burst_r;
        count_nxt   = tick_count;
        tick_nxt    = 1'b0;
        clk_out_nxt = 1'b0;
        done_nxt    = done;

        if (cfg_accept) begin
            incr_nxt  = cfg_incr;
            burst_nxt = cfg_burst;
            done_nxt  = 1'b0;
        end

        case (state)
            IDLE, DONE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    done_nxt  = 1'b0;
                end
            end
            RUN: begin
                // stop discards any carry produced in the same cycle
                if (stop) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else begin
                    tick_nxt = carry;
                    if (carry) begin
                        count_nxt = count_inc;
                    end
                    if (last_tick) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        acc_nxt     = sum[ACC_WIDTH-1:0];
                        clk_out_nxt = sum[ACC_WIDTH-1];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_ref or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state      <= IDLE;
            acc        <= '0;
            incr_r     <= '0;
            burst_r    <= '0;
            tick_count <= '0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            incr_r     <= incr_nxt;
            burst_r    <= burst_nxt;
            tick_count <= count_nxt;
            tick       <= tick_nxt;
            clk_out    <= clk_out_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_clk_rate_gen.sv
// Directed bench: 8-bit accumulator instance for the detailed cases, default 32-bit instance for the 1/4-rate timebase.
module tb_clk_rate_gen;

    logic        clk_ref;
    logic        reset_in_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_incr;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        tick;
    logic        clk_out;
    logic [15:0] tick_count;

    logic        w_cfg_valid;
    logic        w_cfg_ready;
    logic [31:0] w_cfg_incr;
    logic [31:0] w_cfg_burst;
    logic        w_start;
    logic        w_stop;
    logic        w_busy;
    logic        w_done;
    logic        w_tick;
    logic        w_clk_out;
    logic [31:0] w_tick_count;

    int tests = 0;
    int fails = 0;
    int first_tick;
    int n_ticks;
    logic seen_tick;
    logic seen_clk;

    clk_rate_gen #(
        .CLK_REF_RATE_HZ (100000000),
        .ACC_WIDTH       (8),
        .COUNTER_WIDTH   (16)
    ) u_dut (
        .clk_ref    (clk_ref),
        .reset_in_n (reset_in_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_incr   (cfg_incr),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .tick       (tick),
        .clk_out    (clk_out),
        .tick_count (tick_count)
    );

    clk_rate_gen u_dut32 (
        .clk_ref    (clk_ref),
        .reset_in_n (reset_in_n),
        .cfg_valid  (w_cfg_valid),
        .cfg_ready  (w_cfg_ready),
        .cfg_incr   (w_cfg_incr),
        .cfg_burst  (w_cfg_burst),
        .start      (w_start),
        .stop       (w_stop),
        .busy       (w_busy),
        .done       (w_done),
        .tick       (w_tick),
        .clk_out    (w_clk_out),
        .tick_count (w_tick_count)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_ref);
        #1;
    endtask

    initial begin
        reset_in_n  = 1'b0;
        cfg_valid   = 1'b0;
        cfg_incr    = 8'd0;
        cfg_burst   = 16'd0;
        start       = 1'b0;
        stop        = 1'b0;
        w_cfg_valid = 1'b0;
        w_cfg_incr  = 32'd0;
        w_cfg_burst = 32'd0;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        #2;
        check("rst_tick", tick, 1'b0);
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", tick_count, 16'd0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        cycle();
        cycle();
        reset_in_n = 1'b1;
        cycle();

        // incr=64 continuous; mid-run config offers and start pulses must be ignored
        cfg_valid = 1'b1; cfg_incr = 8'd64; cfg_burst = 16'd0; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        check("run_busy", busy, 1'b1);
        check("run_cfg_ready", cfg_ready, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                cfg_valid = 1'b1; cfg_incr = 8'd3; cfg_burst = 16'd2; start = 1'b1;
            end
            cycle();
            check("i64_tick", tick, (k % 4) == 0);
            check("i64_clk_out", clk_out, ((k % 4) == 2) || ((k % 4) == 3));
        end
        cfg_valid = 1'b0; start = 1'b0;
        check("i64_count20", tick_count, 16'd5);
        check("i64_cfg_ready", cfg_ready, 1'b0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop1_busy", busy, 1'b0);
        check("stop1_count", tick_count, 16'd5);
        check("stop1_done", done, 1'b0);

        // stop at RUN cycle 10 (incr still 64 since mid-run offers were refused)
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) cycle();
        check("pre_stop_count", tick_count, 16'd2);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_busy", busy, 1'b0);
        check("stop_cfg_ready", cfg_ready, 1'b1);
        check("stop_count", tick_count, 16'd2);
        check("stop_tick", tick, 1'b0);
        cycle();
        cycle();
        check("stop_no_tick12", tick, 1'b0);
        check("stop_hold_count", tick_count, 16'd2);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 1'b0);
        check("start_stop_count", tick_count, 16'd2);

        // burst of 3 at incr=128
        cfg_valid = 1'b1; cfg_incr = 8'd128; cfg_burst = 16'd3;
        cycle();
        cfg_valid = 1'b0;
        check("cfg_idle_busy", busy, 1'b0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("b3_tick", tick, (k % 2) == 0);
            if (k < 6) begin
                check("b3_clk_out", clk_out, (k % 2) == 1);
                check("b3_busy", busy, 1'b1);
                check("b3_done", done, 1'b0);
            end
        end
        check("b3_done_set", done, 1'b1);
        check("b3_busy_clr", busy, 1'b0);
        check("b3_count", tick_count, 16'd3);
        check("b3_cfg_ready", cfg_ready, 1'b1);
        check("b3_clk_out_end", clk_out, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("b3_after_tick", tick, 1'b0);
        end
        check("b3_done_hold", done, 1'b1);
        check("b3_count_hold", tick_count, 16'd3);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("done_stop_noeffect", done, 1'b1);
        cfg_valid = 1'b1; cfg_incr = 8'd32; cfg_burst = 16'd0;
        cycle();
        cfg_valid = 1'b0;
        check("cfg_clears_done", done, 1'b0);

        // cfg accept together with start: new incr=64 replaces 32
        cfg_valid = 1'b1; cfg_incr = 8'd64; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("cfg_start_tick", tick, (k == 4) || (k == 8));
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // incr=3: 3 ticks per 256 cycles, first carry at cycle 86
        cfg_valid = 1'b1; cfg_incr = 8'd3; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        first_tick = 0;
        n_ticks = 0;
        for (int k = 1; k <= 2560; k++) begin
            cycle();
            if (tick) begin
                n_ticks++;
                if (first_tick == 0) first_tick = k;
            end
            if (k == 256) check("i3_count256", tick_count, 16'd3);
        end
        check("i3_first", first_tick, 86);
        check("i3_nticks", n_ticks, 30);
        check("i3_count", tick_count, 16'd30);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // incr=0: running but silent
        cfg_valid = 1'b1; cfg_incr = 8'd0; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        seen_tick = 1'b0;
        seen_clk = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            seen_tick = seen_tick | tick;
            seen_clk = seen_clk | clk_out;
        end
        check("i0_no_tick", seen_tick, 1'b0);
        check("i0_no_clk", seen_clk, 1'b0);
        check("i0_busy", busy, 1'b1);
        check("i0_count", tick_count, 16'd0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // incr=255: tick every cycle after the first
        cfg_valid = 1'b1; cfg_incr = 8'd255; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("i255_tick", tick, k != 1);
        end
        check("i255_count", tick_count, 16'd9);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // 32-bit default instance at a quarter of the reference rate
        w_cfg_valid = 1'b1; w_cfg_incr = 32'h4000_0000; w_start = 1'b1;
        cycle();
        w_cfg_valid = 1'b0; w_start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            cycle();
            if (k == 3) check("w_tick3", w_tick, 1'b0);
            if (k == 4) check("w_tick4", w_tick, 1'b1);
        end
        check("w_count400", w_tick_count, 32'd100);
        check("w_busy", w_busy, 1'b1);

        // asynchronous reset while both instances run
        cfg_valid = 1'b1; cfg_incr = 8'd64; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 6; k++) cycle();
        check("pre_rst_count", tick_count, 16'd1);
        check("pre_rst_clk_out", clk_out, 1'b1);
        #2;
        reset_in_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_clk_out", clk_out, 1'b0);
        check("arst_tick", tick, 1'b0);
        check("arst_count", tick_count, 16'd0);
        check("arst_cfg_ready", cfg_ready, 1'b1);
        check("arst_w_count", w_tick_count, 32'd0);
        check("arst_w_busy", w_busy, 1'b0);
        cycle();
        reset_in_n = 1'b1;
        cycle();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_tick", tick, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
